lcd_hd44780_writer: RTL and testbench

LCD_HD44780_WRITER -- requirements
Module: lcd_hd44780_writer

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_delay_timer.sv | 32 +++
 rtl/lcd_hd44780_writer.sv | 180 ++++++++++++++++++
 tb/tb_lcd_hd44780_writer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 writer: the FSM state encoding, the
// HD44780 command bytes and the default timing values (50 MHz clock).
package lcd_pkg;

    localparam int unsigned CNT_W    = 20;
    localparam int unsigned ROM_LAST = 5;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_ISSUE,
        IDLE,
        SETUP,
        EN_HIGH,
        HOLD,
        EXEC_WAIT
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DDRAM_L1   = 8'h80;
    localparam logic [7:0] CMD_DDRAM_L2   = 8'hC0;

    localparam int unsigned DEF_T_PWR       = 750000;
    localparam int unsigned DEF_T_SU        = 2;
    localparam int unsigned DEF_T_EN        = 24;
    localparam int unsigned DEF_T_HOLD      = 2;
    localparam int unsigned DEF_T_EXEC      = 2000;
    localparam int unsigned DEF_T_EXEC_LONG = 82000;
    localparam int unsigned DEF_T_INIT1     = 205000;
    localparam int unsigned DEF_T_INIT2     = 5000;

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every timed state of the writer.
// Loading N makes done rise N clocks later; N of 0 or 1 gives one clock.
// Ports: clk, load (restart with load_val), load_val, done (count reached 0).
module lcd_delay_timer
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Next count: load N-1 so the owning state lasts exactly N clocks.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = (load_val == '0) ? '0 : load_val - CNT_W'(1);
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Owner holds load during its reset, so no separate reset is needed here.
    always_ff @(posedge clk) begin
        cnt  <= cnt_next;
        done <= (cnt_next == '0);
    end

endmodule

// File: rtl/lcd_hd44780_writer.sv
// HD44780 8-bit write-only controller: runs the power-on init sequence,
// then accepts command/data bytes from a valid/ready client and strobes
// them onto the panel bus with setup, enable-width, hold and execution waits.
// Ports: CLOCK_50, RESET (sync, active high); client wr_valid/wr_is_data/
// wr_byte/wr_ready; init_done; panel LCD_ON, LCD_EN, LCD_RS, LCD_RW, LCD_DATA.
module lcd_hd44780_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR       = DEF_T_PWR,
    parameter int unsigned T_SU        = DEF_T_SU,
    parameter int unsigned T_EN        = DEF_T_EN,
    parameter int unsigned T_HOLD      = DEF_T_HOLD,
    parameter int unsigned T_EXEC      = DEF_T_EXEC,
    parameter int unsigned T_EXEC_LONG = DEF_T_EXEC_LONG,
    parameter int unsigned T_INIT1     = DEF_T_INIT1,
    parameter int unsigned T_INIT2     = DEF_T_INIT2
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       wr_valid,
    input  logic       wr_is_data,
    input  logic [7:0] wr_byte,
    output logic       wr_ready,
    output logic       init_done,
    output logic       LCD_ON,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    lcd_state_t       state;
    lcd_state_t       state_next;
    logic [2:0]       rom_idx;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic [7:0]       rom_byte_c;
    logic [CNT_W-1:0] exec_len_c;

    lcd_delay_timer u_timer (
        .clk      (CLOCK_50),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Power-on init ROM.
    always_comb begin
        rom_byte_c = CMD_ENTRY_MODE;
        case (rom_idx)
            3'd0, 3'd1, 3'd2: rom_byte_c = CMD_FUNC_SET;
            3'd3:             rom_byte_c = CMD_DISPLAY_ON;
            3'd4:             rom_byte_c = CMD_CLEAR;
            default:          rom_byte_c = CMD_ENTRY_MODE;
        endcase
    end

    // Execution wait for the byte currently on the bus (bus holds the captured byte).
    always_comb begin
        if (!init_done && rom_idx == 3'd0) begin
            exec_len_c = CNT_W'(T_INIT1);
        end else if (!init_done && rom_idx == 3'd1) begin
            exec_len_c = CNT_W'(T_INIT2);
        end else if (!LCD_RS && (LCD_DATA == CMD_CLEAR || LCD_DATA == CMD_HOME)) begin
            exec_len_c = CNT_W'(T_EXEC_LONG);
        end else begin
            exec_len_c = CNT_W'(T_EXEC);
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= PWR_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and timer load; every timed state loads the timer on entry.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            PWR_WAIT: begin
                if (tmr_done) begin
                    state_next = INIT_ISSUE;
                end
            end
            INIT_ISSUE: begin
                state_next = SETUP;
                tmr_load   = 1'b1;
                tmr_val    = CNT_W'(T_SU);
            end
            IDLE: begin
                if (wr_valid) begin
                    state_next = SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(T_SU);
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_next = EN_HIGH;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(T_EN);
                end
            end
            EN_HIGH: begin
                if (tmr_done) begin
                    state_next = HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(T_HOLD);
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_next = EXEC_WAIT;
                    tmr_load   = 1'b1;
                    tmr_val    = exec_len_c;
                end
            end
            EXEC_WAIT: begin
                if (tmr_done) begin
                    if (init_done || rom_idx == 3'(ROM_LAST)) begin
                        state_next = IDLE;
                    end else begin
                        state_next = INIT_ISSUE;
                    end
                end
            end
            default: begin
                state_next = PWR_WAIT;
            end
        endcase
        if (RESET) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_PWR);
        end
    end

    // Registered outputs. wr_ready follows the next state so it is high exactly
    // while the FSM sits in IDLE; EN follows the current state, giving the
    // extra clock of RS/DATA setup before the rising edge.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rom_idx   <= 3'd0;
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
            LCD_ON    <= 1'b1;
            LCD_EN    <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_RW    <= 1'b0;
            LCD_DATA  <= 8'h00;
        end else begin
            LCD_ON   <= 1'b1;
            LCD_RW   <= 1'b0;
            wr_ready <= (state_next == IDLE);
            LCD_EN   <= (state == EN_HIGH);
            // Bus doubles as the capture register; it only changes when a new byte starts.
            if (state == INIT_ISSUE) begin
                LCD_RS   <= 1'b0;
                LCD_DATA <= rom_byte_c;
            end else if (state == IDLE && wr_valid) begin
                LCD_RS   <= wr_is_data;
                LCD_DATA <= wr_byte;
            end
            if (state == EXEC_WAIT && tmr_done && !init_done) begin
                if (rom_idx == 3'(ROM_LAST)) begin
                    init_done <= 1'b1;
                end else begin
                    rom_idx <= rom_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Self-checking bench for lcd_hd44780_writer with short timing parameters.
module tb_lcd_hd44780_writer;

    localparam int unsigned P_PWR       = 20;
    localparam int unsigned P_SU        = 2;
    localparam int unsigned P_EN        = 4;
    localparam int unsigned P_HOLD      = 2;
    localparam int unsigned P_EXEC      = 5;
    localparam int unsigned P_EXEC_LONG = 30;
    localparam int unsigned P_INIT1     = 15;
    localparam int unsigned P_INIT2     = 8;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       wr_valid   = 1'b0;
    logic       wr_is_data = 1'b0;
    logic [7:0] wr_byte    = 8'h00;
    logic       wr_ready;
    logic       init_done;
    logic       lcd_on;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    int cyc      = 0;
    int n_chk    = 0;
    int n_err    = 0;
    int stab_bad = 0;

    int ev_rise[$];
    int ev_data[$];
    int ev_rs[$];
    int ev_width[$];

    logic       en_q      = 1'b0;
    int         en_w      = 0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_rs   = 1'b0;

    typedef struct {
        logic [7:0] d;
        int         gap;   // clocks from previous EN rise (first: from reset release)
    } init_t;

    typedef struct {
        logic       is_data;
        logic [7:0] b;
        int         ret;   // accept edge to wr_ready return
    } vec_t;

    init_t init_tab[6];
    vec_t  vecs[7];

    lcd_hd44780_writer #(
        .T_PWR       (P_PWR),
        .T_SU        (P_SU),
        .T_EN        (P_EN),
        .T_HOLD      (P_HOLD),
        .T_EXEC      (P_EXEC),
        .T_EXEC_LONG (P_EXEC_LONG),
        .T_INIT1     (P_INIT1),
        .T_INIT2     (P_INIT2)
    ) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .wr_valid   (wr_valid),
        .wr_is_data (wr_is_data),
        .wr_byte    (wr_byte),
        .wr_ready   (wr_ready),
        .init_done  (init_done),
        .LCD_ON     (lcd_on),
        .LCD_EN     (lcd_en),
        .LCD_RS     (lcd_rs),
        .LCD_RW     (lcd_rw),
        .LCD_DATA   (lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // EN pulse monitor: logs rise time, bus contents and width of every pulse.
    always @(negedge clk) begin
        if (lcd_en && !en_q) begin
            ev_rise.push_back(cyc);
            ev_data.push_back(int'(lcd_data));
            ev_rs.push_back(int'(lcd_rs));
            hold_data <= lcd_data;
            hold_rs   <= lcd_rs;
            en_w      <= 1;
        end else if (lcd_en) begin
            en_w <= en_w + 1;
            if (lcd_data != hold_data || lcd_rs != hold_rs) stab_bad <= stab_bad + 1;
        end
        if (!lcd_en && en_q) ev_width.push_back(en_w);
        en_q <= lcd_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    task automatic ev_clear();
        ev_rise.delete();
        ev_data.delete();
        ev_rs.delete();
        ev_width.delete();
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!wr_ready) begin
            if (n++ > 3000) begin
                ok = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_init(output int c, output bit ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!init_done) begin
            if (n++ > 3000) begin
                ok = 1'b0;
                c  = cyc;
                return;
            end
            @(negedge clk);
        end
        c = cyc;
    endtask

    // Checks the six init pulses that follow a reset released at cycle rel.
    task automatic check_init(input int rel, input string tag);
        int c;
        bit ok;
        wait_init(c, ok);
        chk({tag, " init_done reached"}, int'(ok), 1);
        chk({tag, " init pulse count"}, ev_rise.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s init data[%0d]", tag, i), at(ev_data, i), int'(init_tab[i].d));
            chk($sformatf("%s init rs[%0d]", tag, i), at(ev_rs, i), 0);
            chk($sformatf("%s init width[%0d]", tag, i), at(ev_width, i), int'(P_EN));
            chk($sformatf("%s init gap[%0d]", tag, i),
                at(ev_rise, i) - ((i == 0) ? rel : at(ev_rise, i - 1)), init_tab[i].gap);
        end
        // Rise is seen one clock into EN_HIGH: (T_EN-1) + T_HOLD + T_EXEC = 10.
        chk({tag, " init_done after last rise"}, c - at(ev_rise, 5), 10);
        chk({tag, " wr_ready with init_done"}, int'(wr_ready), 1);
    endtask

    // Sends one byte from IDLE; a is the accept edge.
    task automatic send(input logic is_data, input logic [7:0] b,
                        output int a, output int ret, output bit ok);
        wait_ready(ok);
        a   = cyc + 1;
        ret = -1;
        if (!ok) return;
        ev_clear();
        wr_is_data = is_data;
        wr_byte    = b;
        wr_valid   = 1'b1;
        @(negedge clk);
        // Scramble inputs after accept; the write in progress must not change.
        wr_valid   = 1'b0;
        wr_is_data = ~is_data;
        wr_byte    = ~b;
        wait_ready(ok);
        ret = cyc - a;
    endtask

    initial begin
        int    rel, a, ret, n;
        bit    ok;
        int    acc[16];
        string msg;

        // Gaps: first = T_PWR + INIT_ISSUE + T_SU + 1; later = T_EN+T_HOLD+wait+1+T_SU.
        init_tab[0] = '{8'h38, 24};
        init_tab[1] = '{8'h38, 24};   // after T_INIT1=15
        init_tab[2] = '{8'h38, 17};   // after T_INIT2=8
        init_tab[3] = '{8'h0C, 14};   // after T_EXEC
        init_tab[4] = '{8'h01, 14};   // after T_EXEC
        init_tab[5] = '{8'h06, 39};   // after T_EXEC_LONG for 0x01

        vecs[0] = '{1'b1, 8'h41, 13};
        vecs[1] = '{1'b0, 8'h01, 38};
        vecs[2] = '{1'b0, 8'h02, 38};
        vecs[3] = '{1'b0, 8'h80, 13};
        vecs[4] = '{1'b0, 8'hC0, 13};
        vecs[5] = '{1'b1, 8'h01, 13};   // data 0x01 uses the normal wait
        vecs[6] = '{1'b1, 8'hFF, 13};

        msg = "TIME 12.34      ";

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset LCD_ON", int'(lcd_on), 1);
        chk("reset LCD_EN", int'(lcd_en), 0);
        chk("reset LCD_RS", int'(lcd_rs), 0);
        chk("reset LCD_RW", int'(lcd_rw), 0);
        chk("reset LCD_DATA", int'(lcd_data), 0);
        chk("reset wr_ready", int'(wr_ready), 0);
        chk("reset init_done", int'(init_done), 0);

        // Init sequence with no client traffic.
        ev_clear();
        rel = cyc;
        rst = 1'b0;
        check_init(rel, "boot");

        // Valid held through reset and init: first accept only in IDLE.
        rst        = 1'b1;
        wr_valid   = 1'b1;
        wr_is_data = 1'b1;
        wr_byte    = 8'h41;
        repeat (3) @(negedge clk);
        ev_clear();
        rst = 1'b0;
        n   = 0;
        @(negedge clk);
        while (!wr_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("held valid: init_done at first ready", int'(init_done), 1);
        chk("held valid: no pulse before init end", ev_rise.size(), 6);
        a = cyc + 1;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("held valid: ready drops after accept", int'(wr_ready), 0);
        wait_ready(ok);
        chk("held valid: ready return", cyc - a, 13);
        chk("held valid: data", at(ev_data, 6), 8'h41);
        chk("held valid: rs", at(ev_rs, 6), 1);
        chk("held valid: width", at(ev_width, 6), int'(P_EN));
        chk("held valid: EN rise latency", at(ev_rise, 6) - a, int'(P_SU) + 1);

        // Table-driven single writes.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].is_data, vecs[i].b, a, ret, ok);
            chk($sformatf("vec%0d ready return", i), ret, vecs[i].ret);
            chk($sformatf("vec%0d pulse count", i), ev_rise.size(), 1);
            chk($sformatf("vec%0d data", i), at(ev_data, 0), int'(vecs[i].b));
            chk($sformatf("vec%0d rs", i), at(ev_rs, 0), int'(vecs[i].is_data));
            chk($sformatf("vec%0d width", i), at(ev_width, 0), int'(P_EN));
            chk($sformatf("vec%0d EN rise latency", i), at(ev_rise, 0) - a, int'(P_SU) + 1);
        end

        // Back-to-back: 13-clock busy period plus the IDLE accept cycle.
        ev_clear();
        wr_is_data = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_ready(ok);
            wr_byte  = msg[i];
            wr_valid = 1'b1;
            acc[i]   = cyc + 1;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wait_ready(ok);
        chk("burst pulse count", ev_rise.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("burst data[%0d]", i), at(ev_data, i), int'(msg[i]));
            chk($sformatf("burst rs[%0d]", i), at(ev_rs, i), 1);
            if (i > 0) begin
                chk($sformatf("burst accept gap[%0d]", i), acc[i] - acc[i - 1], 14);
                chk($sformatf("burst rise gap[%0d]", i), at(ev_rise, i) - at(ev_rise, i - 1), 14);
            end
        end
        chk("burst first EN latency", at(ev_rise, 0) - acc[0], int'(P_SU) + 1);

        // Reset during EN_HIGH aborts the write and reruns full init.
        wait_ready(ok);
        wr_is_data = 1'b1;
        wr_byte    = 8'h55;
        wr_valid   = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("midreset EN seen high", int'(lcd_en), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset EN dropped", int'(lcd_en), 0);
        chk("midreset init_done", int'(init_done), 0);
        chk("midreset wr_ready", int'(wr_ready), 0);
        @(negedge clk);
        ev_clear();
        rel = cyc;
        rst = 1'b0;
        check_init(rel, "rerun");

        chk("bus stable while EN high", stab_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
